// File: rtl/rtc_timekeeper.sv
// hh:mm:ss timekeeper with prescaler, run/hold, checked time load, 12h/24h display and rollover strobes.
// Optional alarm compare is built only when RTC_ALARM_EN is defined.
module rtc_timekeeper #(
  parameter int CLK_PER_SEC = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       mode_12h,
  input  logic       load,
  input  logic [4:0] load_hh,
  input  logic [5:0] load_mm,
  input  logic [5:0] load_ss,
  output logic [4:0] hh,
  output logic [5:0] mm,
  output logic [5:0] ss,
  output logic       pm,
  output logic       sec_pulse,
  output logic       min_pulse,
  output logic       hour_pulse,
  output logic       day_pulse,
  output logic       load_err
`ifdef RTC_ALARM_EN
  ,
  input  logic       alarm_set,
  input  logic [4:0] alarm_hh,
  input  logic [5:0] alarm_mm,
  output logic       alarm_hit
`endif
);

  localparam int PS_W = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(CLK_PER_SEC - 1);

  logic [PS_W-1:0] ps_q, ps_d;
  logic [4:0]      h_q, h_d;
  logic [5:0]      mm_q, mm_d;
  logic [5:0]      ss_q, ss_d;
  logic            sec_q, sec_d, min_q, min_d, hour_q, hour_d, day_q, day_d;
  logic            load_err_q, load_err_d;
  logic            tick, load_ok;

  always_comb begin
    load_ok    = (load_hh <= 5'd23) && (load_mm <= 6'd59) && (load_ss <= 6'd59);
    tick       = en && (ps_q == PS_LAST);
    ps_d       = ps_q;
    h_d        = h_q;
    mm_d       = mm_q;
    ss_d       = ss_q;
    sec_d      = 1'b0;
    min_d      = 1'b0;
    hour_d     = 1'b0;
    day_d      = 1'b0;
    load_err_d = 1'b0;
    // A load takes priority over counting; a rejected load freezes everything for that edge.
    if (load) begin
      if (load_ok) begin
        h_d  = load_hh;
        mm_d = load_mm;
        ss_d = load_ss;
        ps_d = '0;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (en) begin
      if (tick) begin
        ps_d  = '0;
        sec_d = 1'b1;
        if (ss_q == 6'd59) begin
          ss_d  = 6'd0;
          min_d = 1'b1;
          if (mm_q == 6'd59) begin
            mm_d   = 6'd0;
            hour_d = 1'b1;
            if (h_q == 5'd23) begin
              h_d   = 5'd0;
              day_d = 1'b1;
            end else begin
              h_d = h_q + 5'd1;
            end
          end else begin
            mm_d = mm_q + 6'd1;
          end
        end else begin
          ss_d = ss_q + 6'd1;
        end
      end else begin
        ps_d = ps_q + PS_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ps_q       <= '0;
      h_q        <= 5'd0;
      mm_q       <= 6'd0;
      ss_q       <= 6'd0;
      sec_q      <= 1'b0;
      min_q      <= 1'b0;
      hour_q     <= 1'b0;
      day_q      <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      ps_q       <= ps_d;
      h_q        <= h_d;
      mm_q       <= mm_d;
      ss_q       <= ss_d;
      sec_q      <= sec_d;
      min_q      <= min_d;
      hour_q     <= hour_d;
      day_q      <= day_d;
      load_err_q <= load_err_d;
    end
  end

  // Display mapping only; the internal hour is always 0..23.
  always_comb begin
    hh = h_q;
    if (mode_12h) begin
      if (h_q == 5'd0)       hh = 5'd12;
      else if (h_q > 5'd12)  hh = h_q - 5'd12;
    end
  end

  assign pm         = (h_q >= 5'd12);
  assign mm         = mm_q;
  assign ss         = ss_q;
  assign sec_pulse  = sec_q;
  assign min_pulse  = min_q;
  assign hour_pulse = hour_q;
  assign day_pulse  = day_q;
  assign load_err   = load_err_q;

`ifdef RTC_ALARM_EN
  logic       armed_q, armed_d;
  logic [4:0] al_hh_q, al_hh_d;
  logic [5:0] al_mm_q, al_mm_d;
  logic       hit_q, hit_d;

  // Only a counting advance can fire the alarm, so the match is gated by a non-load tick.
  always_comb begin
    armed_d = armed_q;
    al_hh_d = al_hh_q;
    al_mm_d = al_mm_q;
    hit_d   = tick && !load && armed_q && (h_d == al_hh_q) && (mm_d == al_mm_q) && (ss_d == 6'd0);
    if (alarm_set && (alarm_hh <= 5'd23) && (alarm_mm <= 6'd59)) begin
      armed_d = 1'b1;
      al_hh_d = alarm_hh;
      al_mm_d = alarm_mm;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed_q <= 1'b0;
      al_hh_q <= 5'd0;
      al_mm_q <= 6'd0;
      hit_q   <= 1'b0;
    end else begin
      armed_q <= armed_d;
      al_hh_q <= al_hh_d;
      al_mm_q <= al_mm_d;
      hit_q   <= hit_d;
    end
  end

  assign alarm_hit = hit_q;
`endif

endmodule

// File: tb/tb_rtc_timekeeper.sv
// Bench for rtc_timekeeper: driver pushes expected outputs from a seconds-of-day model,
// a negedge monitor pops and compares the full output vector every cycle.
module tb_rtc_timekeeper;
  localparam int CPS = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       mode_12h = 1'b0;
  logic       load = 1'b0;
  logic [4:0] load_hh = 5'd0;
  logic [5:0] load_mm = 6'd0;
  logic [5:0] load_ss = 6'd0;
  logic       alarm_set = 1'b0;
  logic [4:0] alarm_hh = 5'd0;
  logic [5:0] alarm_mm = 6'd0;
  logic [4:0] hh;
  logic [5:0] mm, ss;
  logic       pm, sec_pulse, min_pulse, hour_pulse, day_pulse, load_err;
  logic       alarm_hit_w;

  rtc_timekeeper #(.CLK_PER_SEC(CPS)) dut (
    .clk(clk), .rst(rst), .en(en), .mode_12h(mode_12h), .load(load),
    .load_hh(load_hh), .load_mm(load_mm), .load_ss(load_ss),
    .hh(hh), .mm(mm), .ss(ss), .pm(pm),
    .sec_pulse(sec_pulse), .min_pulse(min_pulse), .hour_pulse(hour_pulse),
    .day_pulse(day_pulse), .load_err(load_err)
`ifdef RTC_ALARM_EN
    , .alarm_set(alarm_set), .alarm_hh(alarm_hh), .alarm_mm(alarm_mm), .alarm_hit(alarm_hit_w)
`endif
  );
`ifndef RTC_ALARM_EN
  assign alarm_hit_w = 1'b0;
`endif

  always #5 clk = ~clk;

  // Scoreboard
  logic [23:0] exp_q[$];
  logic [23:0] exp_v, act_v;
  int n_checks = 0;
  int n_pass = 0;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      act_v = {hh, mm, ss, pm, sec_pulse, min_pulse, hour_pulse, day_pulse, load_err, alarm_hit_w};
      n_checks++;
      if (act_v === exp_v) n_pass++;
      else $display("FAIL outputs t=%0t: got hh=%0d mm=%0d ss=%0d pm/sec/min/hour/day/err/alarm=%b expected hh=%0d mm=%0d ss=%0d flags=%b",
                    $time, act_v[23:19], act_v[18:13], act_v[12:7], act_v[6:0],
                    exp_v[23:19], exp_v[18:13], exp_v[12:7], exp_v[6:0]);
    end
  end

  // Reference model: time as seconds of the day, prescaler as a plain count
  int m_t = 0;
  int m_ps = 0;
  bit m_armed = 0;
  int m_ahh = 0;
  int m_amm = 0;

  function automatic logic [23:0] model_vec(bit md, bit s, bit mi, bit ho, bit da, bit er, bit hit);
    int h, dh;
    h  = m_t / 3600;
    dh = md ? ((h % 12 == 0) ? 12 : h % 12) : h;
    return {5'(dh), 6'((m_t / 60) % 60), 6'(m_t % 60), (h >= 12), s, mi, ho, da, er, hit};
  endfunction

  task automatic drive(input logic r, input logic e, input logic ld, input logic md,
                       input logic [4:0] lh, input logic [5:0] lm, input logic [5:0] ls);
    bit s, mi, ho, da, er, hit;
    s = 0; mi = 0; ho = 0; da = 0; er = 0; hit = 0;
    @(negedge clk);
    #1;
    rst = r; en = e; load = ld; mode_12h = md;
    load_hh = lh; load_mm = lm; load_ss = ls;
    if (r) begin
      m_t = 0; m_ps = 0; m_armed = 0;
    end else begin
      if (ld) begin
        if (lh <= 23 && lm <= 59 && ls <= 59) begin
          m_t = int'(lh) * 3600 + int'(lm) * 60 + int'(ls);
          m_ps = 0;
        end else er = 1;
      end else if (e) begin
        if (m_ps == CPS - 1) begin
          m_ps = 0;
          m_t  = (m_t + 1) % 86400;
          s  = 1;
          mi = (m_t % 60 == 0);
          ho = (m_t % 3600 == 0);
          da = (m_t == 0);
          hit = m_armed && (m_t == m_ahh * 3600 + m_amm * 60);
        end else m_ps++;
      end
      if (alarm_set && alarm_hh <= 23 && alarm_mm <= 59) begin
        m_armed = 1; m_ahh = alarm_hh; m_amm = alarm_mm;
      end
    end
    exp_q.push_back(model_vec(md, s, mi, ho, da, er, hit));
  endtask

  task automatic run(input int n, input logic e, input logic md);
    for (int i = 0; i < n; i++) drive(1'b0, e, 1'b0, md, 5'd0, 6'd0, 6'd0);
  endtask

  task automatic load_time(input logic e, input logic md, input logic [4:0] lh,
                           input logic [5:0] lm, input logic [5:0] ls);
    drive(1'b0, e, 1'b1, md, lh, lm, ls);
  endtask

  initial begin
    // Reset in both display modes
    drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 6'd0, 6'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 6'd0, 6'd0);
    // First seconds after reset
    run(8, 1'b1, 1'b0);
    // Day rollover
    load_time(1'b1, 1'b0, 5'd23, 6'd59, 6'd58);
    run(9, 1'b1, 1'b0);
    // Rejected loads, mid-second
    load_time(1'b1, 1'b0, 5'd1, 6'd2, 6'd3);
    run(2, 1'b1, 1'b0);
    load_time(1'b1, 1'b0, 5'd24, 6'd0, 6'd0);
    load_time(1'b1, 1'b0, 5'd0, 6'd60, 6'd0);
    load_time(1'b0, 1'b0, 5'd0, 6'd0, 6'd60);
    run(3, 1'b1, 1'b0);
    // Display mapping around midnight and noon
    load_time(1'b0, 1'b1, 5'd0, 6'd0, 6'd5);
    run(1, 1'b0, 1'b0);
    load_time(1'b0, 1'b1, 5'd12, 6'd0, 6'd5);
    run(1, 1'b0, 1'b0);
    load_time(1'b0, 1'b1, 5'd13, 6'd0, 6'd5);
    run(1, 1'b0, 1'b0);
    run(1, 1'b0, 1'b1);
    // Hold mid-second, then a load on the terminal prescaler edge
    load_time(1'b1, 1'b0, 5'd10, 6'd20, 6'd30);
    run(2, 1'b1, 1'b0);
    run(10, 1'b0, 1'b0);
    run(1, 1'b1, 1'b0);
    load_time(1'b1, 1'b0, 5'd4, 6'd5, 6'd6);
    run(6, 1'b1, 1'b1);
    // Mid-operation reset with a load pending
    load_time(1'b1, 1'b0, 5'd9, 6'd9, 6'd9);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 5'd3, 6'd3, 6'd3);
    run(5, 1'b1, 1'b0);
`ifdef RTC_ALARM_EN
    alarm_set = 1'b1; alarm_hh = 5'd7; alarm_mm = 6'd30;
    run(1, 1'b0, 1'b0);
    alarm_hh = 5'd24;
    run(1, 1'b0, 1'b0);
    alarm_set = 1'b0;
    load_time(1'b1, 1'b0, 5'd7, 6'd29, 6'd58);
    run(12, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 6'd0, 6'd0);
    load_time(1'b1, 1'b0, 5'd7, 6'd29, 6'd58);
    run(12, 1'b1, 1'b0);
`endif
    // Randomized traffic, loads biased towards rollover boundaries
    for (int i = 0; i < 3000; i++) begin
      logic r, e, ld, md;
      logic [4:0] lh;
      logic [5:0] lm, ls;
      r  = ($urandom_range(0, 499) == 0);
      e  = ($urandom_range(0, 9) < 8);
      ld = ($urandom_range(0, 19) == 0);
      md = ($urandom_range(0, 3) == 0) ? 1'b1 : mode_12h;
      if ($urandom_range(0, 1) == 0) begin
        lh = 5'($urandom_range(0, 31));
        lm = 6'($urandom_range(0, 63));
        ls = 6'($urandom_range(0, 63));
      end else begin
        lh = ($urandom_range(0, 1) == 0) ? 5'd23 : 5'd11;
        lm = 6'($urandom_range(58, 59));
        ls = 6'($urandom_range(55, 59));
      end
`ifdef RTC_ALARM_EN
      alarm_set = ($urandom_range(0, 49) == 0);
      alarm_hh  = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom_range(0, 25));
      alarm_mm  = ($urandom_range(0, 1) == 0) ? 6'd0 : 6'($urandom_range(0, 61));
`endif
      drive(r, e, ld, md, lh, lm, ls);
    end
    alarm_set = 1'b0;
    run(2, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending entries, required 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rtc_timekeeper.md
Name: rtc_timekeeper

Overview:
Parametrised hh:mm:ss timekeeper that generalises the free-running min/sec counter.
- Adds an internal clock prescaler, run/hold control, synchronous time load with range checking, and a runtime-selectable 12h/24h display format.
- Outputs one-cycle rollover strobes.
- Sits between the system clock domain and display/alarm logic; one instance per displayed clock.

Parameters:
- CLK_PER_SEC, default 4, number of enabled clk cycles per second; must be >= 1; CLK_PER_SEC=1 advances one second every enabled cycle.
- PS_W, default $clog2(CLK_PER_SEC) (minimum 1), prescaler counter width; derived, not overridden.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  run enable; 0 holds the prescaler and time.
- mode_12h  in  1  display format: 0 = 24h, 1 = 12h; affects outputs only.
- load  in  1  one-cycle request to load load_hh/mm/ss.
- load_hh  in  5  hours to load, 24h encoding 0..23.
- load_mm  in  6  minutes to load, 0..59.
- load_ss  in  6  seconds to load, 0..59.
- hh  out  5  displayed hours: 0..23 (24h) or 1..12 (12h).
- mm  out  6  minutes.
- ss  out  6  seconds.
- pm  out  1  1 when internal hour >= 12, in both modes.
- sec_pulse  out  1  one-cycle strobe on every second advance.
- min_pulse  out  1  one-cycle strobe on ss 59->0.
- hour_pulse  out  1  one-cycle strobe on mm:ss 59:59->00:00.
- day_pulse  out  1  one-cycle strobe on 23:59:59->00:00:00.
- load_err  out  1  one-cycle strobe when a load is rejected.

Behaviour:
Interface:
- One clock (clk).
- Asynchronous, active-high reset (rst).
- All state updates on the rising edge of clk.

Reset:
- Internal hour h, mm, ss and the prescaler all go to 0.
- All strobes and load_err go to 0.
- hh reads 0 in 24h mode, 12 in 12h mode; pm = 0.
- Reset asserted mid-operation clears immediately; an in-flight load is discarded.

Prescaler:
- Counts 0..CLK_PER_SEC-1 while en=1.
- At the terminal count it wraps to 0 and generates a tick on the same edge.
- The first tick occurs on the CLK_PER_SEC-th enabled edge after reset or load.
- With en=0 the prescaler holds its value.

Tick advance:
- ss increments.
- ss==59 -> ss=0 and mm increments.
- mm==59 with ss==59 -> mm=0 and h increments.
- h==23 with mm:ss==59:59 -> h=0.
- All digit updates take effect on the same edge.

Strobes:
- Registered, high for exactly the one cycle following the advancing edge, coincident with the new time values.
- Nested rollovers assert together, e.g. day_pulse implies hour_pulse, min_pulse and sec_pulse.

Load:
- Sampled on any edge with load=1, regardless of en.
- Valid when load_hh <= 23, load_mm <= 59 and load_ss <= 59.
- Valid load: writes h/mm/ss and clears the prescaler to 0. No strobes are generated.
- Invalid load: time and prescaler are unchanged; load_err = 1 for one cycle.
- Load coinciding with a tick: load wins and the tick is dropped.

Display mapping (combinational from h):
- 24h: hh = h.
- 12h: hh = 12 if h is 0 or 12, otherwise h mod 12.
- pm = (h >= 12).
- Changing mode_12h never changes internal state.

Optional Feature:
Macro: RTC_ALARM_EN
- With the macro defined, the block adds these ports:
  - alarm_set  in  1
  - alarm_hh  in  5
  - alarm_mm  in  6
  - alarm_hit  out  1
- alarm_set=1 with a valid alarm_hh (<= 23) and alarm_mm (<= 59) registers the alarm and arms it. An invalid value is ignored.
- alarm_hit pulses one cycle when a tick produces h:mm:ss == alarm_hh:alarm_mm:00. Loads never fire the alarm.
- Reset disarms the alarm.
- Without the macro: no alarm ports or logic; the rest of the behaviour is identical.

Test Plan:
1. CLK_PER_SEC=4, rst pulse, en=1 for 8 cycles -> ss = 1 after cycle 4, ss = 2 after cycle 8; sec_pulse high on cycles 5 and 9 only.
2. load 23:59:58, en=1, run 8 cycles -> ss 59, then 00:00:00; day/hour/min/sec_pulse all high one cycle; pm goes 1->0.
3. load_hh=24, then load_mm=60 -> load_err pulses each time; time unchanged; prescaler unchanged.
4. mode_12h=1 with h = 0, 12, 13 -> hh = 12/pm 0, 12/pm 1, 1/pm 1; toggling to 24h shows 0, 12, 13 with ss unaffected.
5. en=0 for 10 cycles mid-second, then load coincident with a terminal prescaler tick -> time frozen while en=0; load value wins and no sec_pulse occurs on that edge.
6. RTC_ALARM_EN: alarm 07:30, load 07:29:58 -> alarm_hit one cycle when 07:30:00 is reached; reset disarms it and no hit occurs after reload.
